dest_reg_pipe: RTL

- Write-side counterpart of the ID-stage read-register decoders in the 5-stage THCO-MIPS16 pipeline.
- Decodes each instruction's destination register in ID and carries it through the EX, MEM and WB stages.
- WB stage drives the register-file write port.
- Compares ID-stage read addresses against in-flight destinations to produce forwarding selects and a load-use stall request.

---
 rtl/dest_reg_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe: decodes the ID-stage destination register, carries it through EX/MEM/WB,
// and produces forwarding selects plus the load-use stall request for the ID read ports.
module dest_reg_pipe #(
    parameter logic [3:0] REG_SP = 4'b1000,
    parameter logic [3:0] REG_T  = 4'b1001,
    parameter logic [3:0] REG_IH = 4'b1010,
    parameter logic [3:0] REG_RA = 4'b1011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic [3:0]  rd_a,
    input  logic [3:0]  rd_b,
    input  logic        rd_a_used,
    input  logic        rd_b_used,
    input  logic        stall,
    input  logic        flush,
    output logic [3:0]  ex_wreg,
    output logic [3:0]  mem_wreg,
    output logic [3:0]  wb_wreg,
    output logic        ex_wen,
    output logic        mem_wen,
    output logic        wb_wen,
    output logic        ex_load,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        load_use
);
    logic [4:0] w_op;
    logic [7:0] w_lo8;
    logic [4:0] w_lo5;
    logic [3:0] w_rx, w_ry, w_rz;
    logic [3:0] w_dec_wreg;
    logic       w_dec_wen, w_dec_load, w_bubble;
    logic [3:0] r_ex_wreg, r_mem_wreg, r_wb_wreg;
    logic       r_ex_wen, r_mem_wen, r_wb_wen, r_ex_load;

    assign w_op  = id_instr[15:11];
    assign w_lo8 = id_instr[7:0];
    assign w_lo5 = id_instr[4:0];
    assign w_rx  = {1'b0, id_instr[10:8]};
    assign w_ry  = {1'b0, id_instr[7:5]};
    assign w_rz  = {1'b0, id_instr[4:2]};

    always_comb begin
        w_dec_wen  = 1'b1;
        w_dec_wreg = 4'b0000;
        w_dec_load = 1'b0;
        case (w_op)
            5'b01001, 5'b01101, 5'b01111, 5'b00110: w_dec_wreg = w_rx;
            5'b10010: begin
                w_dec_wreg = w_rx;
                w_dec_load = 1'b1;
            end
            5'b01000: w_dec_wreg = w_ry;
            5'b10011: begin
                w_dec_wreg = w_ry;
                w_dec_load = 1'b1;
            end
            5'b11100: w_dec_wreg = w_rz;
            5'b01110, 5'b01010, 5'b01011: w_dec_wreg = REG_T;
            5'b01100: begin
                if (id_instr[10:8] == 3'b011 || id_instr[10:8] == 3'b100) w_dec_wreg = REG_SP;
                else w_dec_wen = 1'b0;
            end
            // 11101 shares one opcode between ALU ops, compares, MFPC, JALR and JR variants
            5'b11101: begin
                if (w_lo8 == 8'h40) w_dec_wreg = w_rx;
                else if (w_lo8 == 8'hC0) w_dec_wreg = REG_RA;
                else if (w_lo5 == 5'b01100 || w_lo5 == 5'b01011 || w_lo5 == 5'b01111 || w_lo5 == 5'b01101) w_dec_wreg = w_rx;
                else if (w_lo5 == 5'b01010 || w_lo5 == 5'b00010 || w_lo5 == 5'b00011) w_dec_wreg = REG_T;
                else w_dec_wen = 1'b0;
            end
            5'b11110: begin
                if (w_lo8 == 8'h00) w_dec_wreg = w_rx;
                else if (w_lo8 == 8'h01) w_dec_wreg = REG_IH;
                else w_dec_wen = 1'b0;
            end
            default: w_dec_wen = 1'b0;
        endcase
    end

    assign w_bubble = stall | flush | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_wen   <= 1'b0;
            r_ex_wreg  <= 4'b0000;
            r_ex_load  <= 1'b0;
            r_mem_wen  <= 1'b0;
            r_mem_wreg <= 4'b0000;
            r_wb_wen   <= 1'b0;
            r_wb_wreg  <= 4'b0000;
        end else begin
            r_ex_wen   <= ~w_bubble & w_dec_wen;
            r_ex_wreg  <= w_bubble ? 4'b0000 : w_dec_wreg;
            r_ex_load  <= ~w_bubble & w_dec_load;
            r_mem_wen  <= r_ex_wen;
            r_mem_wreg <= r_ex_wreg;
            r_wb_wen   <= r_mem_wen;
            r_wb_wreg  <= r_mem_wreg;
        end
    end

    function automatic logic [1:0] sel(input logic [3:0] r, input logic u);
        return !u ? 2'b00 :
               (r_ex_wen  && r_ex_wreg  == r) ? 2'b01 :
               (r_mem_wen && r_mem_wreg == r) ? 2'b10 :
               (r_wb_wen  && r_wb_wreg  == r) ? 2'b11 : 2'b00;
    endfunction

    assign fwd_a    = sel(rd_a, rd_a_used);
    assign fwd_b    = sel(rd_b, rd_b_used);
    assign load_use = r_ex_load & r_ex_wen &
                      ((rd_a_used & (r_ex_wreg == rd_a)) | (rd_b_used & (r_ex_wreg == rd_b)));

    assign ex_wreg  = r_ex_wreg;
    assign mem_wreg = r_mem_wreg;
    assign wb_wreg  = r_wb_wreg;
    assign ex_wen   = r_ex_wen;
    assign mem_wen  = r_mem_wen;
    assign wb_wen   = r_wb_wen;
    assign ex_load  = r_ex_load;
endmodule
